// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state type; the transmitter should take
// its BAUD_DIV from here too so both ends always agree on the bit period.
package uart_pkg;

  localparam logic [11:0] BAUD_DIV   = 12'hA2C;
  localparam logic [11:0] HALF_DIV   = BAUD_DIV >> 1;
  localparam logic [3:0]  FRAME_BITS = 4'd10;

  typedef enum logic {
    IDLE,
    RECV
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous pad input; both flops reset to 1
// so an idle-high line does not look like activity after reset.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ff1_q <= 1'b1;
      ff2_q <= 1'b1;
    end else begin
      ff1_q <= async_i;
      ff2_q <= ff1_q;
    end
  end

  assign sync_o = ff2_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with rdy/clr_rdy handshake. Defining UART_RX_FRM_ERR_EN
// adds the frm_err output, flagging a frame whose stop bit was sampled low.
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [11:0] BIT_CLKS  = BAUD_DIV,
  parameter logic [11:0] HALF_CLKS = HALF_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
`ifdef UART_RX_FRM_ERR_EN
  ,
  output logic       frm_err
`endif
);

  logic        rx_ff2;
  logic        rx_ff3_q;
  rx_state_t   state_q, state_d;
  logic [11:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  shift_reg_q, shift_reg_d;
  logic        rdy_q, rdy_d;
  logic        start;
  logic        set_rdy;

  uart_sync2 u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (RX),
    .sync_o  (rx_ff2)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_ff3_q    <= 1'b1;
      state_q     <= IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_reg_q <= 9'h1FF;
      rdy_q       <= 1'b0;
    end else begin
      rx_ff3_q    <= rx_ff2;
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_reg_q <= shift_reg_d;
      rdy_q       <= rdy_d;
    end
  end

  // baud_cnt holds clocks-to-next-sample minus one, so the zero-check cycle is
  // itself the sample clock and samples land exactly one bit period apart.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_reg_d = shift_reg_q;
    start       = 1'b0;
    set_rdy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_ff3_q && !rx_ff2) begin
          start      = 1'b1;
          state_d    = RECV;
          baud_cnt_d = HALF_CLKS - 12'd1;
          bit_cnt_d  = '0;
        end
      end
      RECV: begin
        if (bit_cnt_q == FRAME_BITS) begin
          state_d = IDLE;
          set_rdy = 1'b1;
        end else if (baud_cnt_q == '0) begin
          shift_reg_d = {rx_ff2, shift_reg_q[8:1]};
          baud_cnt_d  = BIT_CLKS - 12'd1;
          bit_cnt_d   = bit_cnt_q + 4'd1;
        end else begin
          baud_cnt_d = baud_cnt_q - 12'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_d = rdy_q;
    if (set_rdy) rdy_d = 1'b1;
    else if (start || clr_rdy) rdy_d = 1'b0;
  end

  assign rx_data = shift_reg_q[7:0];
  assign rdy     = rdy_q;

`ifdef UART_RX_FRM_ERR_EN
  logic frm_err_q, frm_err_d;

  always_comb begin
    frm_err_d = frm_err_q;
    if (set_rdy) frm_err_d = ~shift_reg_q[8];
    else if (start || clr_rdy) frm_err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) frm_err_q <= 1'b0;
    else        frm_err_q <= frm_err_d;
  end

  assign frm_err = frm_err_q;
`endif

endmodule
